// File: rtl/local_flit_injector.sv
// Local-port network interface: packs PE words into HEAD/BODY/TAIL flits for router input 0
// and gates injection on a single credit pool shared by the router's local input VCs.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module local_flit_injector #(
  parameter int unsigned NUM_VC      = 4,
  parameter int unsigned VC_DEPTH    = 4,
  parameter int unsigned MAX_PKT_LEN = 8,
  parameter int unsigned FLIT_W      = `FLIT_DATA_WIDTH,
  localparam int unsigned Pool       = NUM_VC * VC_DEPTH,
  localparam int unsigned CntW       = $clog2(Pool + 1),
  localparam int unsigned IdxW       = (MAX_PKT_LEN > 2) ? $clog2(MAX_PKT_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              msg_valid,
  input  logic [FLIT_W-3:0] msg_data,
  input  logic              msg_last,
  output logic              msg_ready,
  output logic [FLIT_W-1:0] flit_data,
  output logic              flit_valid,
  input  logic              credit_increment,
  output logic [CntW-1:0]   credit_cnt,
  output logic              credit_err,
  output logic              len_err,
  output logic [15:0]       pkt_count
);

  typedef enum logic [0:0] {StIdle, StBody} state_e;

  localparam logic [1:0] TypeBody = 2'b00;
  localparam logic [1:0] TypeHead = 2'b01;
  localparam logic [1:0] TypeTail = 2'b10;
  localparam logic [1:0] TypeOne  = 2'b11;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   flit_idx_q, flit_idx_d;
  logic [FLIT_W-1:0] flit_data_q, flit_data_d;
  logic              flit_valid_q, flit_valid_d;
  logic [CntW-1:0]   credit_cnt_q, credit_cnt_d;
  logic              credit_err_q, credit_err_d;
  logic              len_err_q, len_err_d;
  logic [15:0]       pkt_count_q, pkt_count_d;

  logic       accept;
  logic [1:0] flit_type;
  logic       emit_tail;
  logic       forced_tail;

  assign msg_ready = (credit_cnt_q != '0);
  assign accept    = msg_valid & msg_ready;

  always_comb begin
    state_d     = state_q;
    flit_idx_d  = flit_idx_q;
    flit_type   = TypeBody;
    emit_tail   = 1'b0;
    forced_tail = 1'b0;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (msg_last) begin
            flit_type = TypeOne;
            emit_tail = 1'b1;
          end else begin
            flit_type  = TypeHead;
            state_d    = StBody;
            flit_idx_d = IdxW'(1);
          end
        end
        StBody: begin
          if (msg_last || (flit_idx_q == IdxW'(MAX_PKT_LEN - 1))) begin
            flit_type   = TypeTail;
            emit_tail   = 1'b1;
            forced_tail = ~msg_last;
            state_d     = StIdle;
            flit_idx_d  = '0;
          end else begin
            flit_type  = TypeBody;
            flit_idx_d = flit_idx_q + IdxW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    flit_valid_d = accept;
    flit_data_d  = accept ? {flit_type, msg_data} : flit_data_q;
    len_err_d    = len_err_q | forced_tail;
    pkt_count_d  = pkt_count_q + 16'(emit_tail);
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    unique case ({accept, credit_increment})
      2'b10: credit_cnt_d = credit_cnt_q - CntW'(1);
      2'b01: begin
        // A return with the pool already full is dropped and flagged.
        if (credit_cnt_q == CntW'(Pool)) credit_err_d = 1'b1;
        else                             credit_cnt_d = credit_cnt_q + CntW'(1);
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      flit_idx_q   <= '0;
      flit_data_q  <= '0;
      flit_valid_q <= 1'b0;
      credit_cnt_q <= CntW'(Pool);
      credit_err_q <= 1'b0;
      len_err_q    <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      flit_idx_q   <= flit_idx_d;
      flit_data_q  <= flit_data_d;
      flit_valid_q <= flit_valid_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
      len_err_q    <= len_err_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign flit_data  = flit_data_q;
  assign flit_valid = flit_valid_q;
  assign credit_cnt = credit_cnt_q;
  assign credit_err = credit_err_q;
  assign len_err    = len_err_q;
  assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_local_flit_injector.sv
// Bench for local_flit_injector: directed scenarios plus random traffic, all checked against a
// packet-level reference model (words per packet, credit arithmetic, tail count).
module tb_local_flit_injector;

  localparam int unsigned FW   = 32;
  localparam int unsigned PW   = FW - 2;
  localparam int unsigned POOL = 16;
  localparam int unsigned MAXL = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          msg_valid = 1'b0;
  logic [PW-1:0] msg_data = '0;
  logic          msg_last = 1'b0;
  logic          msg_ready;
  logic [FW-1:0] flit_data;
  logic          flit_valid;
  logic          credit_increment = 1'b0;
  logic [4:0]    credit_cnt;
  logic          credit_err;
  logic          len_err;
  logic [15:0]   pkt_count;

  local_flit_injector #(
    .NUM_VC(4), .VC_DEPTH(4), .MAX_PKT_LEN(MAXL), .FLIT_W(FW)
  ) dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last),
    .msg_ready(msg_ready), .flit_data(flit_data), .flit_valid(flit_valid),
    .credit_increment(credit_increment), .credit_cnt(credit_cnt), .credit_err(credit_err),
    .len_err(len_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_flits = 0;

  // Reference model state: words already sent in the open packet, credits, flags.
  int            m_words;
  int            m_cred;
  bit            m_cerr;
  bit            m_lerr;
  int            m_pkts;
  bit            exp_valid;
  logic [FW-1:0] exp_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("flit_valid", 64'(flit_valid), 64'(exp_valid));
    check_eq("flit_data", 64'(flit_data), 64'(exp_data));
    check_eq("credit_cnt", 64'(credit_cnt), 64'(m_cred));
    check_eq("credit_err", 64'(credit_err), 64'(m_cerr));
    check_eq("len_err", 64'(len_err), 64'(m_lerr));
    check_eq("pkt_count", 64'(pkt_count), 64'(m_pkts & 16'hffff));
    if (flit_valid === 1'b1) n_flits++;
  endtask

  task automatic model_reset();
    m_words = 0; m_cred = POOL; m_cerr = 0; m_lerr = 0; m_pkts = 0;
    exp_valid = 0; exp_data = '0;
  endtask

  // One cycle: check the previous edge's result at the negedge, then present new inputs.
  task automatic cycle(input bit v, input bit last, input logic [PW-1:0] data, input bit inc);
    bit acc;
    int typ;
    int n;
    @(negedge clk);
    check_outputs();
    msg_valid = v; msg_last = last; msg_data = data; credit_increment = inc;
    check_eq("msg_ready", 64'(msg_ready), 64'(m_cred != 0));
    acc = v && (m_cred != 0);
    exp_valid = acc;
    if (acc) begin
      if (m_words == 0) begin
        typ = last ? 3 : 1;
        m_words = last ? 0 : 1;
        if (last) m_pkts++;
      end else if (last || (m_words + 1 == MAXL)) begin
        typ = 2;
        if (!last) m_lerr = 1;
        m_words = 0;
        m_pkts++;
      end else begin
        typ = 0;
        m_words++;
      end
      exp_data = {2'(typ), data};
    end
    n = m_cred - int'(acc) + int'(inc);
    if (n > POOL) begin
      n = POOL;
      m_cerr = 1;
    end
    m_cred = n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b0; msg_valid = 0; msg_last = 0; credit_increment = 0;
    model_reset();
    #1;
    check_eq("rst_flit_valid", 64'(flit_valid), 64'd0);
    check_eq("rst_flit_data", 64'(flit_data), 64'd0);
    check_eq("rst_credit_cnt", 64'(credit_cnt), 64'(POOL));
    check_eq("rst_pkt_count", 64'(pkt_count), 64'd0);
    check_eq("rst_errs", 64'({credit_err, len_err}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    do_reset();

    // T1: single-flit packet
    cycle(1, 1, PW'('h5A), 0);
    cycle(0, 0, '0, 0);
    check_eq("t1_data", 64'(flit_data), 64'({2'b11, PW'('h5A)}));
    check_eq("t1_cnt", 64'(credit_cnt), 64'd15);

    // T2: 4-flit packet, types checked cycle by cycle
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, i == 3, PW'('hA0 + i), 0);
    cycle(0, 0, '0, 0);
    check_eq("t2_cnt", 64'(credit_cnt), 64'd12);
    check_eq("t2_pkts", 64'(pkt_count), 64'd1);

    // T3: credit exhaustion, then one returned credit
    do_reset();
    n_flits = 0;
    for (int i = 0; i < 20; i++) cycle(1, 1, PW'(i), 0);
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 0);
    check_eq("t3_flits", 64'(n_flits), 64'd16);
    check_eq("t3_ready", 64'(msg_ready), 64'd0);
    cycle(0, 0, '0, 1);
    cycle(1, 1, PW'('h77), 0);
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 0);
    check_eq("t3_flits_after", 64'(n_flits), 64'd17);

    // T4: simultaneous accept+increment at 5, then increment at full pool
    do_reset();
    for (int i = 0; i < 11; i++) cycle(1, 1, PW'(i), 0);
    cycle(1, 1, PW'('h33), 1);
    cycle(0, 0, '0, 0);
    check_eq("t4_cnt5", 64'(credit_cnt), 64'd5);
    do_reset();
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 0);
    check_eq("t4_cnt16", 64'(credit_cnt), 64'd16);
    check_eq("t4_cerr", 64'(credit_err), 64'd1);

    // T5: truncation at MAX_PKT_LEN
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 0, PW'('h100 + i), 0);
    cycle(0, 0, '0, 0);
    check_eq("t5_lerr", 64'(len_err), 64'd1);
    check_eq("t5_pkts", 64'(pkt_count), 64'd1);

    // T6: reset mid-packet
    do_reset();
    cycle(1, 0, PW'('h1), 0);
    cycle(1, 0, PW'('h2), 0);
    do_reset();
    cycle(1, 0, PW'('h3), 0);
    @(posedge clk);
    #1;
    check_eq("t6_type", 64'(flit_data[FW-1 -: 2]), 64'd1);

    // Random traffic, with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, PW'($urandom),
            $urandom_range(0, 2) == 0);
    end
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
